// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encoding and ALUOp codes shared by the multi-cycle controller
package ctrl_pkg;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_B  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_AL  = 4'd7,
        S_WB_L   = 4'd8,
        S_HALT   = 4'd9
    } state_t;
endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: instruction/flag inputs and datapath control outputs of the controller
interface multi_cycle_ctrl_if;
    logic [31:0] Instruction;
    logic        Zero;
    logic        PCWrite;
    logic        PCSrc;
    logic [15:0] Immediate;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        ALUSrcB;
    logic        MemToReg;
    logic [2:0]  ALUOp;
    logic [3:0]  State;
    modport master (
        output Instruction, Zero,
        input  PCWrite, PCSrc, Immediate, IRWrite, MemRead, MemWrite,
               RegWrite, RegDst, ALUSrcB, MemToReg, ALUOp, State
    );
    modport slave (
        input  Instruction, Zero,
        output PCWrite, PCSrc, Immediate, IRWrite, MemRead, MemWrite,
               RegWrite, RegDst, ALUSrcB, MemToReg, ALUOp, State
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: Moore control decode from state and opcode; PCSrc also looks at Zero
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcB,
    output logic       MemToReg,
    output logic [2:0] ALUOp
);
    logic known;
    logic imm_alu;
    assign known   = opcode inside {OP_ADD, OP_SUB, OP_ADDIU, OP_ORI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_HALT};
    assign imm_alu = opcode == OP_ADDIU || opcode == OP_ORI;
    // unknown opcodes retire straight out of ID
    assign PCWrite  = state == S_WB_AL || state == S_EXE_B || state == S_MEM_WR || state == S_WB_L ||
                      (state == S_ID && !known);
    assign PCSrc    = state == S_EXE_B && ((opcode == OP_BEQ && Zero) || (opcode == OP_BNE && !Zero));
    assign IRWrite  = state == S_IF;
    assign MemRead  = state == S_MEM_RD;
    assign MemWrite = state == S_MEM_WR;
    assign RegWrite = state == S_WB_AL || state == S_WB_L;
    assign RegDst   = state == S_WB_AL && (opcode == OP_ADD || opcode == OP_SUB);
    assign ALUSrcB  = (state == S_EXE_AL && imm_alu) || state == S_EXE_LS;
    assign MemToReg = state == S_WB_L;
    assign ALUOp    = (state == S_EXE_B || (state == S_EXE_AL && opcode == OP_SUB)) ? ALU_SUB :
                      (state == S_EXE_AL && opcode == OP_ORI) ? ALU_OR : ALU_ADD;
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle CPU control FSM; state register and next-state logic here
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input logic            CLK,
    input logic            Reset,
    multi_cycle_ctrl_if.slave bus
);
    state_t     state;
    state_t     next;
    logic [5:0] opcode;
    assign opcode        = bus.Instruction[31:26];
    assign bus.Immediate = bus.Instruction[15:0];
    assign bus.State     = state;
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) state <= S_IF;
        else        state <= next;
    always_comb begin
        next = S_IF;
        case (state)
            S_IF:     next = S_ID;
            S_ID:
                case (opcode)
                    OP_ADD, OP_SUB, OP_ADDIU, OP_ORI: next = S_EXE_AL;
                    OP_BEQ, OP_BNE:                   next = S_EXE_B;
                    OP_LW, OP_SW:                     next = S_EXE_LS;
                    OP_HALT:                          next = S_HALT;
                    default:                          next = S_IF;
                endcase
            S_EXE_AL: next = S_WB_AL;
            S_EXE_LS: next = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: next = S_WB_L;
            S_HALT:   next = S_HALT;
            default:  next = S_IF;
        endcase
    end
    ctrl_out_decode u_dec (
        .state    (state),
        .opcode   (opcode),
        .Zero     (bus.Zero),
        .PCWrite  (bus.PCWrite),
        .PCSrc    (bus.PCSrc),
        .IRWrite  (bus.IRWrite),
        .MemRead  (bus.MemRead),
        .MemWrite (bus.MemWrite),
        .RegWrite (bus.RegWrite),
        .RegDst   (bus.RegDst),
        .ALUSrcB  (bus.ALUSrcB),
        .MemToReg (bus.MemToReg),
        .ALUOp    (bus.ALUOp)
    );
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: table, directed and random checks of multi_cycle_ctrl against a per-instruction model
module tb_multi_cycle_ctrl;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010, ORI = 6'b010010;
    localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101, HALT = 6'b111111;
    localparam logic [3:0] ALU_S [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
    localparam logic [3:0] BR_S  [3] = '{4'd0, 4'd1, 4'd3};
    localparam logic [3:0] LW_S  [5] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8};
    localparam logic [3:0] SW_S  [4] = '{4'd0, 4'd1, 4'd4, 4'd6};
    localparam logic [31:0] RST_VEC = {4'd0, 1'b1, 8'b0, 3'b000, 16'h0000};

    logic CLK = 0;
    logic Reset = 0;
    int total = 0;
    int passed = 0;
    always #5 CLK = ~CLK;

    multi_cycle_ctrl_if bus();
    multi_cycle_ctrl dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       zero;
        int         lat;
        logic       pcsrc;
    } vec_t;

    // {State, IRWrite, PCWrite, PCSrc, MemRead, MemWrite, RegWrite, RegDst, ALUSrcB, MemToReg, ALUOp, Immediate}
    function automatic logic [31:0] obs();
        return {bus.State, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.MemRead, bus.MemWrite,
                bus.RegWrite, bus.RegDst, bus.ALUSrcB, bus.MemToReg, bus.ALUOp, bus.Immediate};
    endfunction

    function automatic int n_of(logic [5:0] op);
        if (op inside {ADD, SUB, ADDIU, ORI, SW}) return 4;
        if (op inside {BEQ, BNE}) return 3;
        if (op == LW) return 5;
        return 2;
    endfunction

    // expected outputs at cycle i of one instruction, from its class and position
    function automatic logic [31:0] exp_out(logic [5:0] op, logic z, logic [15:0] imm, int i);
        int n = n_of(op);
        bit alu = op inside {ADD, SUB, ADDIU, ORI};
        bit br = op inside {BEQ, BNE};
        bit lw = op == LW;
        bit sw = op == SW;
        bit last = i == n - 1;
        logic [3:0] st;
        logic [2:0] aop;
        if (i >= n) return '1;
        st = alu ? ALU_S[i] : br ? BR_S[i] : lw ? LW_S[i] : sw ? SW_S[i] : 4'(i);
        aop = i != 2 ? 3'b000 : (op == SUB || br) ? 3'b001 : op == ORI ? 3'b010 : 3'b000;
        return {st, i == 0, last, br && i == 2 && ((op == BEQ) == z), lw && i == 3, sw && i == 3,
                (alu || lw) && last, (op == ADD || op == SUB) && last,
                i == 2 && (op inside {ADDIU, ORI} || lw || sw), lw && last, aop, imm};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // entered at a negedge with State=IF; leaves at the negedge where State is IF again
    task automatic run_instr(string name, logic [5:0] op, logic z, logic [15:0] imm,
                             output int lat, output logic pcsrc_seen);
        bus.Instruction = {op, 10'h000, imm};
        bus.Zero = z;
        lat = 0;
        pcsrc_seen = 0;
        do begin
            check($sformatf("%s c%0d", name, lat), obs(), exp_out(op, z, imm, lat));
            pcsrc_seen |= bus.PCSrc;
            lat++;
            @(negedge CLK);
        end while (bus.State != 4'd0 && lat < 8);
    endtask

    vec_t tbl[11];
    int lat;
    logic ps;

    initial begin
        tbl[0]  = '{"add",    ADD,       1'b0, 4, 1'b0};
        tbl[1]  = '{"sub",    SUB,       1'b1, 4, 1'b0};
        tbl[2]  = '{"addiu",  ADDIU,     1'b0, 4, 1'b0};
        tbl[3]  = '{"ori",    ORI,       1'b0, 4, 1'b0};
        tbl[4]  = '{"sw",     SW,        1'b1, 4, 1'b0};
        tbl[5]  = '{"lw",     LW,        1'b0, 5, 1'b0};
        tbl[6]  = '{"beq z1", BEQ,       1'b1, 3, 1'b1};
        tbl[7]  = '{"beq z0", BEQ,       1'b0, 3, 1'b0};
        tbl[8]  = '{"bne z1", BNE,       1'b1, 3, 1'b0};
        tbl[9]  = '{"bne z0", BNE,       1'b0, 3, 1'b1};
        tbl[10] = '{"unk",    6'b101010, 1'b0, 2, 1'b0};
        bus.Instruction = 32'h0;
        bus.Zero = 0;
        #1 check("reset async", obs(), RST_VEC);
        repeat (2) @(posedge CLK);
        #1 check("reset held", obs(), RST_VEC);
        @(negedge CLK) Reset = 1;

        foreach (tbl[k]) begin
            run_instr(tbl[k].name, tbl[k].op, tbl[k].zero, 16'h1234 + 16'(k), lat, ps);
            check({tbl[k].name, " latency"}, 32'(lat), 32'(tbl[k].lat));
            check({tbl[k].name, " pcsrc"}, {31'b0, ps}, {31'b0, tbl[k].pcsrc});
        end

        bus.Instruction = {HALT, 26'h0};
        check("halt IF", obs(), {4'd0, 1'b1, 11'b0, 16'h0});
        @(negedge CLK) check("halt ID", obs(), {4'd1, 12'b0, 16'h0});
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK) check($sformatf("halt hold %0d", c), obs(), {4'd9, 12'b0, 16'h0});
        end
        #2 Reset = 0;
        #1 check("halt reset", obs(), RST_VEC);
        @(negedge CLK) Reset = 1;
        run_instr("after halt", ADD, 1'b0, 16'h0000, lat, ps);
        check("after halt latency", 32'(lat), 32'd4);

        bus.Instruction = {LW, 10'h0, 16'h0000};
        repeat (3) @(negedge CLK);
        check("lw at mem_rd", {28'b0, bus.State}, 32'd5);
        #2 Reset = 0;
        #1 check("mid reset", obs(), RST_VEC);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK) check($sformatf("mid reset hold %0d", c), obs(), RST_VEC);
        end
        Reset = 1;
        run_instr("after mid reset", ADD, 1'b0, 16'h0000, lat, ps);
        check("after mid reset latency", 32'(lat), 32'd4);

        for (int r = 0; r < 60; r++) begin
            logic [5:0] op;
            logic [5:0] ops [8] = '{ADD, SUB, ADDIU, ORI, SW, LW, BEQ, BNE};
            int sel = $urandom_range(0, 8);
            if (sel < 8) op = ops[sel];
            else do op = 6'($urandom); while (op inside {ADD, SUB, ADDIU, ORI, SW, LW, BEQ, BNE, HALT});
            run_instr($sformatf("rnd%0d op%b", r, op), op, 1'($urandom), 16'($urandom), lat, ps);
            check($sformatf("rnd%0d latency", r), 32'(lat), 32'(n_of(op)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have ports: CLK  input  1  system clock, rising-edge active.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Instruction  input  32  current instruction register contents; opcode = [31:26], immediate = [15:0].
REQ-004 SHALL have port: Zero  input  1  ALU zero flag, valid during execute.
REQ-005 SHALL have ports: PCWrite  output  1  PC update enable; PCSrc  output  1  0 = PC+4, 1 = PC+4+(sign-extended Immediate<<2).
REQ-006 SHALL have port: Immediate  output  16  equals Instruction[15:0], combinational.
REQ-007 SHALL have ports: IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrcB, MemToReg  output  1 each.
REQ-008 SHALL have ports: ALUOp  output  3 (000 add, 001 sub, 010 or) and State  output  4  current state code, for debugging.

Function
REQ-009 SHALL decode these opcodes: ADD 000000, SUB 000001, ADDIU 000010, ORI 010010, SW 110000, LW 110001, BEQ 110100, BNE 110101, HALT 111111.
REQ-010 SHALL implement these states: IF=0, ID=1, EXE_AL=2, EXE_B=3, EXE_LS=4, MEM_RD=5, MEM_WR=6, WB_AL=7, WB_L=8, HALT=9.
REQ-011 SHALL transition IF->ID unconditionally.
REQ-012 SHALL transition from ID as follows: ADD/SUB/ADDIU/ORI->EXE_AL; BEQ/BNE->EXE_B; LW/SW->EXE_LS; HALT->HALT; any other opcode->IF.
REQ-013 SHALL transition EXE_AL->WB_AL->IF; EXE_B->IF; EXE_LS->MEM_RD (LW) or MEM_WR (SW); MEM_RD->WB_L->IF; MEM_WR->IF.
REQ-014 SHALL remain in HALT until Reset.
REQ-015 SHALL set instruction latency (cycles from IF to the next IF) to: R/I ALU 4, branch 3, SW 4, LW 5, unknown opcode 2.
REQ-016 SHALL assert PCWrite for exactly one cycle per instruction, in the final state: WB_AL, EXE_B, MEM_WR, WB_L, or ID for an unknown opcode. PCWrite SHALL never be asserted in HALT.
REQ-017 SHALL drive PCSrc=1 only in EXE_B when (BEQ and Zero=1) or (BNE and Zero=0); PCSrc SHALL be 0 otherwise.
REQ-018 SHALL drive IRWrite=1 only in IF, MemRead=1 only in MEM_RD, and MemWrite=1 only in MEM_WR.
REQ-019 SHALL drive RegWrite=1 only in WB_AL and WB_L; RegDst=1 in WB_AL for ADD/SUB and 0 otherwise; MemToReg=1 only in WB_L.
REQ-020 SHALL drive ALUSrcB=1 in EXE_AL for ADDIU/ORI and in EXE_LS, and 0 otherwise.
REQ-021 SHALL drive ALUOp as: 001 for SUB and in EXE_B, 010 for ORI, 000 otherwise.
REQ-022 SHALL keep all outputs other than Immediate and PCSrc a pure function of state and opcode (Moore-style); PCSrc additionally depends on Zero, combinationally.
REQ-023 SHALL treat Instruction as stable from ID onward; the block holds no copy of the opcode.

Reset
REQ-024 SHALL force State=IF immediately while Reset=0, independent of CLK.
REQ-025 SHALL output during reset: IRWrite=1; PCWrite, PCSrc, MemRead, MemWrite, RegWrite, RegDst, ALUSrcB, MemToReg = 0; ALUOp=000.
REQ-026 SHALL, when Reset is asserted mid-instruction, abandon that instruction with no further PCWrite, MemWrite or RegWrite pulses.
REQ-027 SHALL start fetching in IF on the first rising edge after Reset deasserts.

Structure
REQ-028 SHALL take opcode constants, state encodings and ALUOp codes from the shared package ctrl_pkg.
REQ-029 SHALL place output decoding in one combinational sub-module, ctrl_out_decode (inputs: state, opcode, Zero); the next-state register and logic live in the top module.

Verification
REQ-030 SHALL verify ADD, opcode 000000: states 0,1,2,7,0; PCWrite=1 and RegWrite=1 and RegDst=1 only in cycle 4; PCSrc=0.
REQ-031 SHALL verify BEQ with Zero=1: states 0,1,3,0; in cycle 3 PCWrite=1, PCSrc=1, ALUOp=001. Also BNE with Zero=1: PCWrite=1, PCSrc=0.
REQ-032 SHALL verify LW, 110001: states 0,1,4,5,8,0; MemRead=1 in cycle 4; RegWrite=1 and MemToReg=1 in cycle 5. Also SW: MemWrite=1 and PCWrite=1 together in cycle 4.
REQ-033 SHALL verify HALT, 111111: State=9 held for 20 cycles with PCWrite=0 throughout; Reset low->high then returns State to 0 and fetching resumes.
REQ-034 SHALL verify unknown opcode 101010: states 0,1,0 with PCWrite=1 in ID and no RegWrite or MemWrite.
REQ-035 SHALL verify Reset=0 asserted mid-edge during MEM_RD of LW: State=0 immediately, no RegWrite pulse, IRWrite=1.
